reducer_ctrl: RTL and testbench

Tile-level sequencer for the reducer datapath. It steps through the output tiles of one layer and drives the reducer's `layer_type` and `ipsum_add_en` controls. For each tile it issues the input-psum buffer read, waits for the PE array's multiplier matrix, and hands the reduced `final_psum` vector to the output-psum buffer under a valid/ready handshake. It sits between the layer controller (start/done) and the PE-array / reducer / psum-buffer datapath.

---
 rtl/reducer_ctrl.sv | 178 +++++++++++++++++
 tb/tb_reducer_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/reducer_ctrl.sv
// reducer_ctrl -- tile-level sequencer for the reducer datapath.
//
// Walks the output tiles of one layer. For each tile it optionally reads the
// stored input psums, waits for the PE array's multiplier matrix, and hands
// the reduced final_psum vector to the output-psum buffer under a
// valid/ready handshake. It also drives the reducer's layer_type and
// ipsum_add_en controls.
//
// Optional feature (compile-time macro REDUCER_CTRL_PERF_EN):
//   defined   -> perf_stall_cnt counts WAIT_MUL cycles without mul_valid plus
//                WRITE cycles without opsum_wr_ready; it saturates, clears on
//                an accepted start and holds after done.
//   undefined -> perf_stall_cnt is tied to 0 and no counter exists.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle layer start (only honoured in IDLE)
//   cfg_layer_type      POINTWISE(0) / DEPTHWISE(1), latched on start
//   cfg_ipsum_en        accumulate onto stored input psums, latched on start
//   cfg_tile_num        number of tiles in the layer (0 allowed)
//   busy, done          layer status / one-cycle end-of-layer pulse
//   layer_type          latched layer type to the reducer
//   ipsum_add_en        reducer adds input psums (WRITE cycles only)
//   ipsum_rd_en/addr    input-psum buffer read strobe and tile index
//   mul_valid/ready     PE-array multiplier matrix handshake
//   opsum_wr_valid/addr output-psum buffer write request and tile index
//   opsum_wr_ready      output buffer accepts the write
//   perf_stall_cnt      optional stall counter

module reducer_ctrl #(
    parameter int ADDR_W = 8,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_layer_type,
    input  logic              cfg_ipsum_en,
    input  logic [ADDR_W-1:0] cfg_tile_num,
    output logic              busy,
    output logic              done,
    output logic              layer_type,
    output logic              ipsum_add_en,
    output logic              ipsum_rd_en,
    output logic [ADDR_W-1:0] ipsum_rd_addr,
    input  logic              mul_valid,
    output logic              mul_ready,
    output logic              opsum_wr_valid,
    output logic [ADDR_W-1:0] opsum_wr_addr,
    input  logic              opsum_wr_ready,
    output logic [PERF_W-1:0] perf_stall_cnt
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_IPSUM = 3'd1,
        WAIT_MUL = 3'd2,
        WRITE    = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] tile_idx;
    logic [ADDR_W-1:0] tile_idx_nxt;
    logic [ADDR_W-1:0] tile_num_q;
    logic              ipsum_en_q;
    logic              start_acc;
    logic              last_tile;

    assign start_acc = (state == IDLE) && start;

    // tile_num_q is at least 1 whenever WRITE is reachable, so no underflow.
    assign last_tile = (tile_idx == (tile_num_q - ADDR_ONE));

    // The write handshake and the matrix release happen in the same cycle,
    // so mul_ready follows the buffer's ready combinationally.
    assign mul_ready = opsum_wr_valid && opsum_wr_ready;

    always_comb begin
        state_nxt    = state;
        tile_idx_nxt = tile_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    tile_idx_nxt = '0;
                    if (cfg_tile_num == '0)
                        state_nxt = DONE;
                    else if (cfg_ipsum_en)
                        state_nxt = RD_IPSUM;
                    else
                        state_nxt = WAIT_MUL;
                end
            end
            RD_IPSUM: state_nxt = WAIT_MUL;
            WAIT_MUL: begin
                if (mul_valid)
                    state_nxt = WRITE;
            end
            WRITE: begin
                if (opsum_wr_ready) begin
                    tile_idx_nxt = tile_idx + ADDR_ONE;
                    if (last_tile)
                        state_nxt = DONE;
                    else if (ipsum_en_q)
                        state_nxt = RD_IPSUM;
                    else
                        state_nxt = WAIT_MUL;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered decodes of the next state, so they line up with
    // the state register and are glitch-free. Addresses read as 0 whenever
    // their strobe is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            tile_idx       <= '0;
            tile_num_q     <= '0;
            ipsum_en_q     <= 1'b0;
            layer_type     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            ipsum_add_en   <= 1'b0;
            ipsum_rd_en    <= 1'b0;
            ipsum_rd_addr  <= '0;
            opsum_wr_valid <= 1'b0;
            opsum_wr_addr  <= '0;
        end else begin
            state    <= state_nxt;
            tile_idx <= tile_idx_nxt;
            if (start_acc) begin
                layer_type <= cfg_layer_type;
                ipsum_en_q <= cfg_ipsum_en;
                tile_num_q <= cfg_tile_num;
            end
            busy           <= (state_nxt != IDLE);
            done           <= (state_nxt == DONE);
            ipsum_rd_en    <= (state_nxt == RD_IPSUM);
            ipsum_rd_addr  <= (state_nxt == RD_IPSUM) ? tile_idx_nxt : '0;
            opsum_wr_valid <= (state_nxt == WRITE);
            opsum_wr_addr  <= (state_nxt == WRITE) ? tile_idx_nxt : '0;
            // WRITE is never entered straight from IDLE, so ipsum_en_q is
            // already the latched value here.
            ipsum_add_en   <= (state_nxt == WRITE) && ipsum_en_q;
        end
    end

`ifdef REDUCER_CTRL_PERF_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

    logic [PERF_W-1:0] stall_cnt;
    logic              stall;

    assign stall = ((state == WAIT_MUL) && !mul_valid) ||
                   ((state == WRITE) && !opsum_wr_ready);

    always_ff @(posedge clk) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (start_acc)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + PERF_ONE;
    end

    assign perf_stall_cnt = stall_cnt;
`else
    assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_reducer_ctrl.sv
// Self-checking bench for reducer_ctrl. Each layer is described as a per-tile
// schedule (optional read cycle, mul stall cycles, write stall cycles); the
// bench expands it into an expected per-cycle timeline, drives the PE array
// and output buffer from that timeline and compares every DUT output each
// cycle.
module tb_reducer_ctrl;
    localparam int ADDR_W = 8;
    localparam int PERF_W = 32;
    localparam int MAXC   = 4096;
`ifdef REDUCER_CTRL_PERF_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              cfg_layer_type = 1'b0;
    logic              cfg_ipsum_en = 1'b0;
    logic [ADDR_W-1:0] cfg_tile_num = '0;
    logic              busy, done, layer_type, ipsum_add_en, ipsum_rd_en;
    logic [ADDR_W-1:0] ipsum_rd_addr, opsum_wr_addr;
    logic              mul_valid = 1'b0;
    logic              mul_ready, opsum_wr_valid;
    logic              opsum_wr_ready = 1'b0;
    logic [PERF_W-1:0] perf_stall_cnt;

    int     n_checks = 0;
    int     n_errors = 0;
    bit     prev_lt = 1'b0;
    longint prev_perf = 0;

    // Expected timeline and stimulus, indexed by cycle within a layer.
    bit e_busy [MAXC];
    bit e_done [MAXC];
    bit e_rd   [MAXC];
    bit e_wr   [MAXC];
    bit e_add  [MAXC];
    bit e_mrdy [MAXC];
    bit e_stall[MAXC];
    int e_rda  [MAXC];
    int e_wra  [MAXC];
    bit d_mv   [MAXC];
    bit d_wrdy [MAXC];

    always #5 clk = ~clk;

    reducer_ctrl #(.ADDR_W(ADDR_W), .PERF_W(PERF_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_layer_type(cfg_layer_type), .cfg_ipsum_en(cfg_ipsum_en),
        .cfg_tile_num(cfg_tile_num), .busy(busy), .done(done),
        .layer_type(layer_type), .ipsum_add_en(ipsum_add_en),
        .ipsum_rd_en(ipsum_rd_en), .ipsum_rd_addr(ipsum_rd_addr),
        .mul_valid(mul_valid), .mul_ready(mul_ready),
        .opsum_wr_valid(opsum_wr_valid), .opsum_wr_addr(opsum_wr_addr),
        .opsum_wr_ready(opsum_wr_ready), .perf_stall_cnt(perf_stall_cnt)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_lt"}, layer_type, 0);
        check({tag, "_add"}, ipsum_add_en, 0);
        check({tag, "_rd"}, ipsum_rd_en, 0);
        check({tag, "_rda"}, ipsum_rd_addr, 0);
        check({tag, "_mrdy"}, mul_ready, 0);
        check({tag, "_wr"}, opsum_wr_valid, 0);
        check({tag, "_wra"}, opsum_wr_addr, 0);
        check({tag, "_perf"}, perf_stall_cnt, 0);
    endtask

    task automatic idle_cycles(input int g);
        for (int i = 0; i < g; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            mul_valid = 1'($urandom_range(0, 1));
            opsum_wr_ready = 1'($urandom_range(0, 1));
            #1;
            check("idle_busy", busy, 0);
            check("idle_done", done, 0);
            check("idle_lt", layer_type, 64'(prev_lt));
            check("idle_perf", perf_stall_cnt, 64'(prev_perf));
        end
    endtask

    // mode: 0 no stalls, 1 random stalls, 2 ready low 5 cycles on tile 1 and
    //       mul_valid low 3 cycles on tile 2
    // ign:  0 none, 1 extra start at a random busy cycle, 2 extra start in
    //       the WAIT_MUL cycle of tile 1 (or tile 0)
    // abort_tile: >=0 pulses rst_n low in the first WRITE cycle of that tile
    task automatic run_layer(input bit lt, input bit ipen, input int n,
                             input int mode, input int ign, input int abort_tile);
        int     c, last, ign_cyc, abort_cyc, sm, sw;
        int     wr_start[256];
        int     wait_start[256];
        longint run;
        longint exp_perf;
        for (int i = 0; i < MAXC; i++) begin
            e_busy[i] = 0; e_done[i] = 0; e_rd[i] = 0; e_wr[i] = 0; e_add[i] = 0;
            e_mrdy[i] = 0; e_stall[i] = 0; e_rda[i] = 0; e_wra[i] = 0;
            d_mv[i] = 1'($urandom_range(0, 1));
            d_wrdy[i] = 1'($urandom_range(0, 1));
        end
        c = 1;
        for (int t = 0; t < n; t++) begin
            sm = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            sw = (mode == 1) ? int'($urandom_range(0, 3)) : 0;
            if (mode == 2) begin
                sm = (t == 2) ? 3 : 0;
                sw = (t == 1) ? 5 : 0;
            end
            if (ipen) begin
                e_busy[c] = 1; e_rd[c] = 1; e_rda[c] = t;
                c++;
            end
            wait_start[t] = c;
            for (int s = 0; s <= sm; s++) begin
                e_busy[c] = 1; d_mv[c] = (s == sm); e_stall[c] = (s < sm);
                c++;
            end
            wr_start[t] = c;
            for (int s = 0; s <= sw; s++) begin
                e_busy[c] = 1; e_wr[c] = 1; e_wra[c] = t; e_add[c] = ipen;
                d_mv[c] = 1; d_wrdy[c] = (s == sw); e_mrdy[c] = (s == sw);
                e_stall[c] = (s < sw);
                c++;
            end
        end
        e_busy[c] = 1; e_done[c] = 1;
        last = c;
        ign_cyc = 0;
        if (ign == 1) ign_cyc = int'($urandom_range(1, last));
        if (ign == 2 && n > 0) ign_cyc = wait_start[(n > 1) ? 1 : 0];
        abort_cyc = (abort_tile >= 0) ? wr_start[abort_tile] : -1;

        run = 0;
        for (int k = 0; k <= last; k++) begin
            @(posedge clk); #1;
            start = (k == 0) || (k == ign_cyc);
            if (k == 0) begin
                cfg_layer_type = lt; cfg_ipsum_en = ipen; cfg_tile_num = ADDR_W'(n);
            end else if (k == ign_cyc) begin
                cfg_layer_type = ~lt; cfg_ipsum_en = ~ipen;
                cfg_tile_num = ADDR_W'(n + 1 + int'($urandom_range(0, 20)));
            end else begin
                cfg_layer_type = 1'($urandom_range(0, 1));
                cfg_ipsum_en = 1'($urandom_range(0, 1));
                cfg_tile_num = ADDR_W'($urandom_range(0, 255));
            end
            mul_valid = d_mv[k];
            opsum_wr_ready = d_wrdy[k];
            rst_n = (k != abort_cyc);
            #1;
            if (k == 0) exp_perf = prev_perf;
            else exp_perf = run;
            if (!PERF_EN) exp_perf = 0;
            check($sformatf("busy@%0d", k), busy, 64'(e_busy[k]));
            check($sformatf("done@%0d", k), done, 64'(e_done[k]));
            check($sformatf("rd_en@%0d", k), ipsum_rd_en, 64'(e_rd[k]));
            check($sformatf("rd_addr@%0d", k), ipsum_rd_addr, 64'(e_rda[k]));
            check($sformatf("wr_valid@%0d", k), opsum_wr_valid, 64'(e_wr[k]));
            check($sformatf("wr_addr@%0d", k), opsum_wr_addr, 64'(e_wra[k]));
            check($sformatf("add_en@%0d", k), ipsum_add_en, 64'(e_add[k]));
            check($sformatf("mul_ready@%0d", k), mul_ready, 64'(e_mrdy[k]));
            check($sformatf("layer_type@%0d", k), layer_type, (k == 0) ? 64'(prev_lt) : 64'(lt));
            check($sformatf("perf@%0d", k), perf_stall_cnt, 64'(exp_perf));
            if (k >= 1 && e_stall[k]) run++;
            if (k == abort_cyc) begin
                @(posedge clk); #1;
                rst_n = 1'b1;
                start = 1'b0;
                #1;
                check_all_zero("after_abort");
                prev_lt = 0;
                prev_perf = 0;
                return;
            end
        end
        start = 1'b0;
        prev_lt = lt;
        prev_perf = PERF_EN ? run : 0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_all_zero("reset");
        rst_n = 1'b1;

        // POINTWISE, no ipsum, 4 tiles, no stalls: done on cycle 9.
        run_layer(1'b0, 1'b0, 4, 0, 0, -1);
        // DEPTHWISE with input psums.
        run_layer(1'b1, 1'b1, 3, 0, 0, -1);
        idle_cycles(2);
        // Directed back-pressure: 5 + 3 stall cycles.
        run_layer(1'b0, 1'b0, 4, 2, 0, -1);
        check("perf_total", perf_stall_cnt, PERF_EN ? 64'd8 : 64'd0);
        // Empty layer.
        run_layer(1'b1, 1'b1, 0, 0, 0, -1);
        // Start during WAIT_MUL is ignored.
        run_layer(1'b1, 1'b0, 5, 1, 2, -1);
        // Reset during WRITE of tile 2 of 5, then a fresh layer.
        run_layer(1'b0, 1'b1, 5, 1, 0, 2);
        run_layer(1'b1, 1'b1, 5, 1, 0, -1);
        // Randomized layers, some back-to-back.
        for (int i = 0; i < 20; i++) begin
            run_layer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      int'($urandom_range(0, 12)), 1, int'($urandom_range(0, 2)), -1);
            idle_cycles(int'($urandom_range(0, 2)));
        end
        // Largest layer.
        run_layer(1'b0, 1'b0, 255, 0, 1, -1);
        idle_cycles(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
